div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 32 +++
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage is the master (operands, start, annul); the divider is the
// slave (registered result and ready).
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for the EX stage.
// Signed operands are reduced to magnitudes at the start edge, 32 MSB-first
// iterations run on a 65-bit {rem, quot} work register, and the signs are
// re-applied when the result is registered. Divide by zero yields zero.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        DivFree,
        DivByZero,
        DivOn,
        DivEnd
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [64:0] work_q;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [64:0] work_d;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;

    // Operand preparation: magnitudes of the incoming operands (only used
    // on the start edge). 0x80000000 maps to itself, which is the correct
    // unsigned magnitude.
    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[31];
        op2_neg = bus.signed_div_i & bus.opdata2_i[31];
        op1_mag = op1_neg ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
        op2_mag = op2_neg ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
    end

    // One restoring iteration: shift, trial-subtract, keep or restore.
    // The subtraction is one bit wider than rem so its borrow is the sign.
    always_comb begin
        shifted  = {work_q[63:0], 1'b0};
        diff     = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
        work_d   = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
        quot_fin = (signed_q && q_neg_q) ? (32'd0 - work_d[31:0])  : work_d[31:0];
        rem_fin  = (signed_q && r_neg_q) ? (32'd0 - work_d[63:32]) : work_d[63:32];
    end

    // Control FSM with registered result/ready; annul overrides everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else if (bus.annul_i) begin
            state_q  <= DivFree;
            cnt_q    <= 6'd0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_q  <= 1'b0;
                    result_q <= 64'd0;
                    if (bus.start_i) begin
                        signed_q  <= bus.signed_div_i;
                        q_neg_q   <= op1_neg ^ op2_neg;
                        r_neg_q   <= op1_neg;
                        work_q    <= {33'd0, op1_mag};
                        divisor_q <= op2_mag;
                        cnt_q     <= 6'd0;
                        state_q   <= (bus.opdata2_i == 32'd0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    result_q <= 64'd0;
                    ready_q  <= 1'b1;
                    state_q  <= DivEnd;
                end
                DivOn: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_q <= {rem_fin, quot_fin};
                        ready_q  <= 1'b1;
                        state_q  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (!bus.start_i) begin
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                        state_q  <= DivFree;
                    end
                end
                default: begin
                    state_q <= DivFree;
                end
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: expected results come from a behavioural
// model using native division and are queued at issue, popped at ready.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [63:0] exp_q[$];

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Issue a divide, queue its expected result and wait (bounded) for ready.
    // lat = number of edges after E0 until ready is seen, -1 on timeout.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] obs, output int lat);
        @(negedge clk);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        obs = bus.result_o;
        $display("div s=%0d a=%h b=%h -> result=%h lat=%0d", s, a, b, obs, lat);
    endtask

    // Drop start and sample the outputs one edge later.
    task automatic release_div(output logic rdy, output logic [63:0] res);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rdy = bus.ready_o;
        res = bus.result_o;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd0;
        bus.opdata2_i = 32'd0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b result=%h, want ready=0 result=0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_unsigned;
        logic [31:0] a_tab [4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd1000000};
        logic [31:0] b_tab [4] = '{32'd7, 32'd1, 32'd9, 32'd333};
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        for (int k = 0; k < 4; k++) begin
            run_div(1'b0, a_tab[k], b_tab[k], obs, lat);
            exp = exp_q.pop_front();
            checks++;
            if (lat != 32) begin
                errors++;
                $display("FAIL divu_latency[%0d]: got %0d, want 32", k, lat);
            end
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL divu_result[%0d]: got %h, want %h", k, obs, exp);
            end
            if (k == 0) begin
                // start stays high: result must be held
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
                    errors++;
                    $display("FAIL divu_hold: ready=%b result=%h, want 1 %h", bus.ready_o, bus.result_o, exp);
                end
            end
            release_div(rdy, res);
            checks++;
            if (rdy !== 1'b0 || res !== 64'd0) begin
                errors++;
                $display("FAIL divu_release[%0d]: ready=%b result=%h, want 0 0", k, rdy, res);
            end
        end
    endtask

    task automatic test_signed;
        logic [31:0] a_tab [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FF9C};
        logic [31:0] b_tab [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [63:0] fixed [3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD, 64'h0000_0000_8000_0000};
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        for (int k = 0; k < 4; k++) begin
            run_div(1'b1, a_tab[k], b_tab[k], obs, lat);
            exp = exp_q.pop_front();
            checks++;
            if (lat != 32 || obs !== exp) begin
                errors++;
                $display("FAIL div_signed[%0d]: got %h lat %0d, want %h lat 32", k, obs, lat, exp);
            end
            if (k < 3) begin
                checks++;
                if (obs !== fixed[k]) begin
                    errors++;
                    $display("FAIL div_signed_const[%0d]: got %h, want %h", k, obs, fixed[k]);
                end
            end
            release_div(rdy, res);
        end
    endtask

    task automatic test_div_zero;
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        run_div(1'b0, 32'd1234, 32'd0, obs, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 1 || obs !== exp) begin
            errors++;
            $display("FAIL divzero_u: got %h lat %0d, want %h lat 1", obs, lat, exp);
        end
        release_div(rdy, res);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, obs, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 1 || obs !== exp) begin
            errors++;
            $display("FAIL divzero_s: got %h lat %0d, want %h lat 1", obs, lat, exp);
        end
        release_div(rdy, res);
    endtask

    task automatic test_operand_stability;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        exp_q.push_back(model(1'b0, 32'd1000, 32'd7));
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                @(negedge clk);
                bus.opdata1_i = 32'hFFFF_0000;
                bus.opdata2_i = 32'd3;
                bus.signed_div_i = 1'b1;
            end
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        exp = exp_q.pop_front();
        $display("div stability a=1000 b=7 -> result=%h lat=%0d", bus.result_o, lat);
        checks++;
        if (lat != 32 || bus.result_o !== exp) begin
            errors++;
            $display("FAIL operand_stability: got %h lat %0d, want %h lat 32", bus.result_o, lat, exp);
        end
        release_div(rdy, res);
    endtask

    task automatic test_annul;
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        int seen;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL annul_outputs: ready=%b result=%h, want 0 0", bus.ready_o, bus.result_o);
        end
        // annul held with start high must keep the unit idle
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) seen++;
        end
        $display("annul at iteration 10: ready seen %0d times", seen);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_no_ready: ready high %0d cycles, want 0", seen);
        end
        run_div(1'b0, 32'd9, 32'd3, obs, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 32 || obs !== exp) begin
            errors++;
            $display("FAIL annul_followup: got %h lat %0d, want %h lat 32", obs, lat, exp);
        end
        release_div(rdy, res);
    endtask

    task automatic test_reset_mid;
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic rdy;
        int lat;
        // reset during iteration 20
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd4;
        bus.start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_on: ready=%b result=%h, want 0 0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        // reset while a result is being presented
        run_div(1'b0, 32'd500, 32'd3, obs, lat);
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_pre_result: got %h, want %h", obs, exp);
        end
        #2;
        rst = 1'b0;
        #1;
        $display("async reset in DivEnd: ready=%b result=%h", bus.ready_o, bus.result_o);
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_end: ready=%b result=%h, want 0 0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        run_div(1'b0, 32'd123456, 32'd789, obs, lat);
        exp = exp_q.pop_front();
        checks++;
        if (lat != 32 || obs !== exp) begin
            errors++;
            $display("FAIL reset_recover: got %h lat %0d, want %h lat 32", obs, lat, exp);
        end
        release_div(rdy, res);
    endtask

    task automatic test_back_to_back;
        logic [63:0] obs;
        logic [63:0] exp;
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic rdy;
        bit s;
        int lat;
        for (int k = 0; k < 8; k++) begin
            s = k[0];
            a = $urandom;
            b = (k == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            run_div(s, a, b, obs, lat);
            exp = exp_q.pop_front();
            checks++;
            if (lat != ((b == 32'd0) ? 1 : 32) || obs !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h lat %0d, want %h", k, obs, lat, exp);
            end
            release_div(rdy, res);
            checks++;
            if (rdy !== 1'b0 || res !== 64'd0) begin
                errors++;
                $display("FAIL b2b_release[%0d]: ready=%b result=%h, want 0 0", k, rdy, res);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_operand_stability();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
